slave_in_port: RTL

//  Slave-side bus receiver, directly downstream of the master transmit port. Deserialises the
//  LSB-first bit streams (slave id, address, burst count, data) into parallel words.

---
 rtl/slave_in_port.sv | 297 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/slave_in_port.sv
// slave_in_port
//   Slave-side bus receiver that sits directly downstream of the master transmit
//   port. It deserialises the LSB-first slave id, address, burst count and data
//   lanes into parallel words. It issues single-cycle write/read strobes to the
//   local memory, drives slave_ready back to the master, and pulses write_done
//   when a write burst completes.
//
//   Ports
//     clk          in   system clock, rising edge
//     reset        in   asynchronous active-low reset
//     sel_bit      in   serial slave-id bit, qualified by sel_valid
//     sel_valid    in   slave-id bit qualifier
//     addr_bit     in   serial address bit
//     burst_bit    in   serial burst-count bit
//     data_bit     in   serial data bit, qualified by master_valid
//     master_valid in   data_bit qualifier; low in RX_DATA is a stall
//     write_en     in   write command level
//     read_en      in   read command level
//     slave_ready  out  selected and able to accept a command
//     mem_addr     out  local memory address [ADDR_LEN]
//     mem_wdata    out  local memory write data [DATA_LEN]
//     mem_we       out  1-cycle write strobe
//     mem_re       out  1-cycle read strobe
//     write_done   out  1-cycle pulse after the last write beat
//     cmd_err      out  1-cycle pulse on a protocol error
//
//   Build option
//     SLAVE_IN_TIMEOUT_EN : when defined, 32 consecutive stall cycles in RX_DATA
//                           abort the write with cmd_err. The partial word is
//                           dropped and no write_done is issued. When undefined,
//                           RX_DATA waits indefinitely.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   S_IDLE     | waiting for the first slave-id bit
//   S_SELECT   | shifting in the remaining slave-id bits
//   S_WAIT_CMD | selected; waiting for write_en / read_en (timed)
//   S_RX_HDR   | shifting in the address and burst-count lanes
//   S_RD_ISSUE | issue the read strobe and release the bus
//   S_RX_DATA  | shifting in data words, one write strobe per word
//   S_DONE     | pulse write_done and release the bus

module slave_in_port #(
  parameter int SLAVE_LEN   = 2,
  parameter int SLAVE_ID    = 0,
  parameter int ADDR_LEN    = 12,
  parameter int DATA_LEN    = 8,
  parameter int BURST_LEN   = 12,
  parameter int CMD_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sel_bit,
  input  logic                sel_valid,
  input  logic                addr_bit,
  input  logic                burst_bit,
  input  logic                data_bit,
  input  logic                master_valid,
  input  logic                write_en,
  input  logic                read_en,
  output logic                slave_ready,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [DATA_LEN-1:0] mem_wdata,
  output logic                mem_we,
  output logic                mem_re,
  output logic                write_done,
  output logic                cmd_err
);

  localparam int HDR_LEN  = (ADDR_LEN > BURST_LEN) ? ADDR_LEN : BURST_LEN;
  localparam int SCNT_W   = (SLAVE_LEN > 1) ? $clog2(SLAVE_LEN) : 1;
  // hcnt must be able to hold ADDR_LEN/BURST_LEN themselves for the lane-enable compares
  localparam int HCNT_W   = $clog2(HDR_LEN + 1);
  localparam int DCNT_W   = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
  localparam int DATA_TMO = 32;
  localparam int TMR_W    = ($clog2(CMD_TIMEOUT) > 5) ? $clog2(CMD_TIMEOUT) : 5;

  localparam logic [SLAVE_LEN-1:0] MY_ID      = SLAVE_LEN'(SLAVE_ID);
  localparam logic [SCNT_W-1:0]    SCNT_LAST  = SCNT_W'(SLAVE_LEN - 1);
  localparam logic [HCNT_W-1:0]    HCNT_LAST  = HCNT_W'(HDR_LEN - 1);
  localparam logic [HCNT_W-1:0]    ADDR_CNT   = HCNT_W'(ADDR_LEN);
  localparam logic [HCNT_W-1:0]    BURST_CNT  = HCNT_W'(BURST_LEN);
  localparam logic [DCNT_W-1:0]    DCNT_LAST  = DCNT_W'(DATA_LEN - 1);
  localparam logic [BURST_LEN-1:0] BEAT_ONE   = BURST_LEN'(1);
  localparam logic [TMR_W-1:0]     TMR_CMD    = TMR_W'(CMD_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]     TMR_DATA   = TMR_W'(DATA_TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_WAIT_CMD,
    S_RX_HDR,
    S_RD_ISSUE,
    S_RX_DATA,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [SLAVE_LEN-1:0] id_q;
  logic [SCNT_W-1:0]    scnt_q;
  logic [HCNT_W-1:0]    hcnt_q;
  logic [ADDR_LEN-1:0]  addr_q;
  logic [BURST_LEN-1:0] burst_q;
  logic [BURST_LEN-1:0] beats_q;
  logic [DATA_LEN-1:0]  word_q;
  logic [DCNT_W-1:0]    dcnt_q;
  logic [TMR_W-1:0]     tmr_q;
  logic                 mode_wr_q;

  // Shift-right with the new bit entering at the MSB: after N shifts the first
  // bit received sits at bit 0, so each lane ends up LSB-first as required.
  logic [SLAVE_LEN-1:0] id_d;
  logic [ADDR_LEN-1:0]  addr_d;
  logic [BURST_LEN-1:0] burst_d;
  logic [BURST_LEN-1:0] burst_nx;
  logic [DATA_LEN-1:0]  word_d;

  assign id_d     = {sel_bit, id_q[SLAVE_LEN-1:1]};
  assign addr_d   = {addr_bit, addr_q[ADDR_LEN-1:1]};
  assign burst_d  = {burst_bit, burst_q[BURST_LEN-1:1]};
  assign burst_nx = (hcnt_q < BURST_CNT) ? burst_d : burst_q;
  assign word_d   = {data_bit, word_q[DATA_LEN-1:1]};

  logic sel_shift;
  logic cmd_go;
  logic hdr_end;
  logic word_end;
  logic err_d;
  logic ready_clr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    sel_shift = 1'b0;
    cmd_go    = 1'b0;
    hdr_end   = 1'b0;
    word_end  = 1'b0;
    err_d     = 1'b0;
    ready_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          sel_shift = 1'b1;
          state_d   = S_SELECT;
        end
      end
      S_SELECT: begin
        if (!sel_valid) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          sel_shift = 1'b1;
          if (scnt_q == SCNT_LAST)
            state_d = (id_d == MY_ID) ? S_WAIT_CMD : S_IDLE;
        end
      end
      S_WAIT_CMD: begin
        if (write_en && read_en) begin
          err_d     = 1'b1;
          ready_clr = 1'b1;
          state_d   = S_IDLE;
        end else if (write_en || read_en) begin
          cmd_go  = 1'b1;
          state_d = S_RX_HDR;
        end else if (tmr_q == '0) begin
          ready_clr = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_RX_HDR: begin
        if (hcnt_q == HCNT_LAST) begin
          hdr_end = 1'b1;
          state_d = mode_wr_q ? S_RX_DATA : S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: begin
        ready_clr = 1'b1;
        state_d   = S_IDLE;
      end
      S_RX_DATA: begin
        if (master_valid) begin
          if (dcnt_q == DCNT_LAST) begin
            word_end = 1'b1;
            if (beats_q == BEAT_ONE) state_d = S_DONE;
          end
        end
`ifdef SLAVE_IN_TIMEOUT_EN
        else if (tmr_q == '0) begin
          err_d     = 1'b1;
          ready_clr = 1'b1;
          state_d   = S_IDLE;
        end
`endif
      end
      S_DONE: begin
        ready_clr = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slave_ready <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      write_done  <= 1'b0;
      cmd_err     <= 1'b0;
      id_q        <= '0;
      scnt_q      <= '0;
      hcnt_q      <= '0;
      addr_q      <= '0;
      burst_q     <= '0;
      beats_q     <= '0;
      word_q      <= '0;
      dcnt_q      <= '0;
      tmr_q       <= '0;
      mode_wr_q   <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      write_done <= 1'b0;
      cmd_err    <= err_d;
      if (ready_clr) slave_ready <= 1'b0;

      if (sel_shift) id_q <= id_d;
      scnt_q <= (state_d == S_SELECT) ? scnt_q + 1'b1 : '0;

      case (state_q)
        S_SELECT: begin
          if (state_d == S_WAIT_CMD) begin
            slave_ready <= 1'b1;
            tmr_q       <= TMR_CMD;
          end
        end
        S_WAIT_CMD: begin
          if (cmd_go) begin
            mode_wr_q <= write_en;
            hcnt_q    <= '0;
          end else if (state_d == S_WAIT_CMD) begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        S_RX_HDR: begin
          if (hcnt_q < ADDR_CNT) addr_q <= addr_d;
          if (hcnt_q < BURST_CNT) burst_q <= burst_d;
          if (hdr_end) begin
            hcnt_q  <= '0;
            dcnt_q  <= '0;
            beats_q <= (burst_nx == '0) ? BEAT_ONE : burst_nx;
            tmr_q   <= TMR_DATA;
          end else begin
            hcnt_q <= hcnt_q + 1'b1;
          end
        end
        S_RD_ISSUE: begin
          mem_addr <= addr_q;
          mem_re   <= 1'b1;
        end
        S_RX_DATA: begin
          if (master_valid) begin
            word_q <= word_d;
            tmr_q  <= TMR_DATA;
            if (word_end) begin
              mem_addr  <= addr_q;
              mem_wdata <= word_d;
              mem_we    <= 1'b1;
              addr_q    <= addr_q + 1'b1;
              beats_q   <= beats_q - 1'b1;
              dcnt_q    <= '0;
            end else begin
              dcnt_q <= dcnt_q + 1'b1;
            end
          end
`ifdef SLAVE_IN_TIMEOUT_EN
          else begin
            tmr_q <= tmr_q - 1'b1;
          end
`endif
        end
        S_DONE: begin
          write_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
